// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared types and constants for the I2C slave register endpoint
package i2c_slave_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int BYTE_W     = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// rtl/i2c_bus_cond.sv - SCL/SDA synchroniser, optional majority filter (I2C_GLITCH_FILTER_EN), edge/START/STOP detect
module i2c_bus_cond
  import i2c_slave_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_c, sda_c, scl_d, sda_d;

  // Idle bus level is high, so reset to 1 to avoid spurious edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_f, sda_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_f <= 3'b111;
      sda_f <= 3'b111;
    end else begin
      scl_f <= {scl_f[1:0], scl_sync[1]};
      sda_f <= {sda_f[1:0], sda_sync[1]};
    end
  end

  assign scl_c = maj3(scl_f);
  assign sda_c = maj3(sda_f);
`else
  assign scl_c = scl_sync[1];
  assign sda_c = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_c;
      sda_d <= sda_c;
    end
  end

  assign sda       = sda_c;
  assign scl_rise  = scl_c & ~scl_d;
  assign scl_fall  = ~scl_c & scl_d;
  assign start_det = scl_c & scl_d & sda_d & ~sda_c;
  assign stop_det  = scl_c & scl_d & ~sda_d & sda_c;

endmodule

// File: rtl/i2c_slave_top.sv
// rtl/i2c_slave_top.sv - I2C slave with byte register file; filter option via I2C_GLITCH_FILTER_EN
module i2c_slave_top
  import i2c_slave_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
  parameter int                    NREGS      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               sda_oe,
  output logic [NREGS*8-1:0] regs_o,
  output logic               busy_o
);

  localparam int PW = $clog2(NREGS);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_cond u_cond (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   sh_q, sh_d, byte_in;
  logic [2:0]          cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                oe_d, rw_q, rw_d, we;
  logic [BYTE_W-1:0]   regs [NREGS];

  assign byte_in = {sh_q[BYTE_W-2:0], sda};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    oe_d    = sda_oe;
    rw_d    = rw_q;
    we      = 1'b0;
    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = byte_in[PW-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                we      = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end
        // sda_oe doubles as the phase flag: first fall drives ACK, second ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 3'd0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d = ST_RDATA;
                sh_d    = regs[ptr_q];
                oe_d    = ~regs[ptr_q][7];
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = ST_RDATA_ACK;
          end else if (scl_fall) begin
            sh_d = {sh_q[BYTE_W-2:0], 1'b0};
            oe_d = ~sh_q[BYTE_W-2];
          end
        end
        // cnt_q==1 marks a master ACK seen on the 9th rise.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == ACK) begin
              ptr_d = ptr_q + 1'b1;
              cnt_d = 3'd1;
            end else begin
              state_d = ST_IGNORE;
              oe_d    = 1'b0;
            end
          end else if (scl_fall) begin
            if (cnt_q == 3'd1) begin
              state_d = ST_RDATA;
              cnt_d   = 3'd0;
              sh_d    = regs[ptr_q];
              oe_d    = ~regs[ptr_q][7];
            end else begin
              oe_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= 3'd0;
      ptr_q  <= '0;
      sda_oe <= 1'b0;
      rw_q   <= 1'b0;
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      sda_oe <= oe_d;
      rw_q   <= rw_d;
      if (we) regs[ptr_q] <= byte_in;
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs_o[8*k +: 8] = regs[k];
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_top.sv
// tb/tb_i2c_slave_top.sv - directed I2C master bench for i2c_slave_top
module tb_i2c_slave_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe;
  logic [31:0] regs_o;
  logic        busy_o;
  wire         sda_line = sda_m & ~sda_oe;

  int n_checks = 0;
  int n_fail = 0;
  int oe_cnt = 0;

  i2c_slave_top dut (
    .clk   (clk),
    .rst   (rst),
    .scl_i (scl),
    .sda_i (sda_line),
    .sda_oe(sda_oe),
    .regs_o(regs_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sda_oe) oe_cnt++;

  task automatic tick();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick();
    scl = 1'b1; tick();
    sda_m = 1'b0; tick();
    scl = 1'b0; tick();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick();
    scl = 1'b1; tick();
    sda_m = 1'b1; tick();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; tick();
      scl = 1'b1; tick(); tick();
      scl = 1'b0; tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; tick();
    scl = 1'b1; tick();
    ack = sda_oe;
    tick();
    scl = 1'b0; tick();
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; tick();
      scl = 1'b1; tick();
      b = {b[6:0], sda_line};
      tick();
      scl = 1'b0; tick();
    end
    sda_m = nack; tick();
    scl = 1'b1; tick(); tick();
    scl = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
    n_checks++; if (regs_o !== 32'h0) begin n_fail++; $display("FAIL reset_regs got %h exp 00000000", regs_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h01, a1);
    send_byte(8'h5A, a2);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL write_busy got %b exp 1", busy_o); end
    i2c_stop();
    tick();
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL write_acks got %b exp 111", {a0, a1, a2}); end
    n_checks++; if (regs_o !== 32'h00005A00) begin n_fail++; $display("FAIL write_regs got %h exp 00005a00", regs_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL write_idle got %b exp 0", busy_o); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] b;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h01, a1);
    i2c_start();
    send_byte(8'hA1, a2);
    recv_byte(1'b1, b);
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL read_acks got %b exp 111", {a0, a1, a2}); end
    n_checks++; if (b !== 8'h5A) begin n_fail++; $display("FAIL read_byte got %h exp 5a", b); end
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_nack_release got %b exp 0", sda_oe); end
    i2c_stop();
    tick();
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    i2c_stop();
    tick();
    n_checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL wrap_acks got %b exp 1111", {a0, a1, a2, a3}); end
    n_checks++; if (regs_o !== 32'h11005A22) begin n_fail++; $display("FAIL wrap_regs got %h exp 11005a22", regs_o); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a1);
    i2c_start();
    send_byte(8'hA1, a2);
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    i2c_stop();
    tick();
    n_checks++; if (b0 !== 8'h11) begin n_fail++; $display("FAIL b2b_byte0 got %h exp 11", b0); end
    n_checks++; if (b1 !== 8'h22) begin n_fail++; $display("FAIL b2b_byte1_wrap got %h exp 22", b1); end
  endtask

  task automatic test_mismatch();
    logic a0, a1, a2;
    int oe_before;
    oe_before = oe_cnt;
    i2c_start();
    send_byte(8'h84, a0);
    send_byte(8'h01, a1);
    send_byte(8'hFF, a2);
    i2c_stop();
    tick();
    n_checks++; if (oe_cnt - oe_before !== 0) begin n_fail++; $display("FAIL mismatch_oe got %0d driven cycles exp 0", oe_cnt - oe_before); end
    n_checks++; if (regs_o !== 32'h11005A22) begin n_fail++; $display("FAIL mismatch_regs got %h exp 11005a22", regs_o); end
  endtask

  task automatic test_abort();
    logic a0, a1;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h00, a1);
    send_bits(8'hF0, 4);
    i2c_stop();
    tick();
    n_checks++; if (regs_o !== 32'h11005A22) begin n_fail++; $display("FAIL abort_regs got %h exp 11005a22", regs_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b exp 0", busy_o); end
  endtask

  task automatic test_rst_mid_read();
    logic a0, a1, a2;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h00, a1);
    i2c_start();
    send_byte(8'hA1, a2);
    // reg0 = 0x22, so its MSB (0) is being driven low right now
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_drive got %b exp 1", sda_oe); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_release got %b exp 0", sda_oe); end
    n_checks++; if (regs_o !== 32'h0) begin n_fail++; $display("FAIL rst_regs got %h exp 00000000", regs_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    @(negedge clk);
    rst = 1'b0;
    i2c_stop();
    tick();
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    sda_m = 1'b0;
    @(negedge clk);
    sda_m = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
    end
    n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL glitch_start got %0d busy cycles exp 0", busy_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_back_to_back();
    test_mismatch();
    test_abort();
    test_rst_mid_read();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
